// File: rtl/exec_datapath.sv
`default_nettype none
// ============================================================================
// Module  : exec_datapath
// Purpose : integer ALU, single-cycle FPU subset (abs/cmp/round.w/cvt.s.w)
//           and the 32x32 FPR with prioritised write arbitration.
// Revision: 1.0
// ============================================================================
module exec_datapath (
    input  logic          clk,
    input  logic          rstn,
    input  logic [31:0]   alu_data_a,
    input  logic [31:0]   alu_data_b,
    input  logic [4:0]    alu_data_c,
    input  logic [3:0]    alu_pattern,
    output logic [31:0]   alu_out,
    input  logic [31:0]   fpu_data_a,
    input  logic [31:0]   fpu_data_b,
    input  logic [5:0]    fpu_data_c,
    input  logic [9:0]    fpu_in_valid,
    output logic [31:0]   fpu_out,
    output logic          fpu_out_valid,
    input  logic          load_finish,
    input  logic          fl_valid,
    input  logic [31:0]   rdata,
    input  logic [4:0]    regaddr,
    input  logic          wfpr_valid2,
    input  logic [31:0]   gpr_out,
    output logic [1023:0] fpr,
    output logic          wfpr_finish
);

    // ---------------- ALU ----------------
    logic [31:0] w_alu_res;

    always_comb begin
        w_alu_res = '0;
        case (alu_pattern)
            4'd0:    w_alu_res = alu_data_a;
            4'd1:    w_alu_res = alu_data_a + alu_data_b;
            4'd2:    w_alu_res = alu_data_a & alu_data_b;
            4'd3:    w_alu_res = alu_data_a | alu_data_b;
            4'd4:    w_alu_res = alu_data_b << alu_data_a[4:0];
            4'd5:    w_alu_res = alu_data_b >> alu_data_a[4:0];
            4'd6:    w_alu_res = alu_data_a - alu_data_b;
            4'd7:    w_alu_res = $signed(alu_data_b) >>> alu_data_a[4:0];
            4'd8:    w_alu_res = ($signed(alu_data_a) < $signed(alu_data_b)) ? 32'd1 : 32'd0;
            4'd9:    w_alu_res = ~(alu_data_a | alu_data_b);
            default: w_alu_res = '0;
        endcase
    end

    assign alu_out = w_alu_res;

    // ---------------- FPU launch decode ----------------
    logic [8:0] w_op;
    logic       w_onehot;
    logic       w_launch;

    assign w_op     = fpu_in_valid[9:1];
    assign w_onehot = (w_op != 9'd0) && ((w_op & (w_op - 9'd1)) == 9'd0);
    assign w_launch = fpu_in_valid[0] & w_onehot;

    // ---------------- compare ----------------
    // Denormals collapse to +0 so that +0, -0 and denormals all compare equal.
    logic        w_a_zero, w_b_zero, w_sa, w_sb, w_eq, w_lt, w_cmp;
    logic [30:0] w_ma, w_mb;

    assign w_a_zero = (fpu_data_a[30:23] == 8'd0);
    assign w_b_zero = (fpu_data_b[30:23] == 8'd0);
    assign w_sa     = fpu_data_a[31] & ~w_a_zero;
    assign w_sb     = fpu_data_b[31] & ~w_b_zero;
    assign w_ma     = w_a_zero ? 31'd0 : fpu_data_a[30:0];
    assign w_mb     = w_b_zero ? 31'd0 : fpu_data_b[30:0];
    assign w_eq     = (w_sa == w_sb) && (w_ma == w_mb);
    assign w_lt     = (w_sa != w_sb) ? w_sa : (w_sa ? (w_ma > w_mb) : (w_ma < w_mb));

    always_comb begin
        w_cmp = 1'b0;
        case (fpu_data_c)
            6'b001100: w_cmp = w_lt;
            6'b010100: w_cmp = w_eq;
            6'b011100: w_cmp = w_lt | w_eq;
            6'b100100: w_cmp = ~w_lt & ~w_eq;
            6'b101100: w_cmp = ~w_eq;
            6'b110100: w_cmp = ~w_lt;
            default:   w_cmp = 1'b0;
        endcase
    end

    // ---------------- round.w (nearest, ties away) ----------------
    logic [7:0]  w_rexp, w_rshr, w_rshl;
    logic [23:0] w_rman;
    logic [55:0] w_rv;
    logic [31:0] w_rmag_r, w_rmag_l, w_rmag, w_round;

    assign w_rexp   = fpu_data_a[30:23];
    assign w_rman   = {1'b1, fpu_data_a[22:0]};
    assign w_rshr   = 8'd150 - w_rexp;
    assign w_rshl   = w_rexp - 8'd150;
    // Bit 31 of the shifted value is the half bit; adding it rounds ties away.
    assign w_rv     = {w_rman, 32'd0} >> w_rshr[4:0];
    assign w_rmag_r = {8'd0, w_rv[55:32]} + {31'd0, w_rv[31]};
    assign w_rmag_l = {8'd0, w_rman} << w_rshl[2:0];
    assign w_rmag   = (w_rexp < 8'd126) ? 32'd0 :
                      (w_rexp < 8'd150) ? w_rmag_r : w_rmag_l;
    assign w_round  = (w_rexp >= 8'd158) ?
                      (fpu_data_a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF) :
                      (fpu_data_a[31] ? -w_rmag : w_rmag);

    // ---------------- cvt.s.w (round to nearest even) ----------------
    logic [31:0] w_cmag, w_cnorm, w_cvt;
    logic [4:0]  w_cpos;
    logic        w_cround;
    logic [24:0] w_csum;
    logic [7:0]  w_cexp;
    logic [22:0] w_cfrac;

    assign w_cmag = fpu_data_a[31] ? -fpu_data_a : fpu_data_a;

    always_comb begin
        w_cpos = '0;
        for (int i = 0; i < 32; i++) begin
            if (w_cmag[i]) w_cpos = i[4:0];
        end
    end

    assign w_cnorm  = w_cmag << (5'd31 - w_cpos);
    assign w_cround = w_cnorm[7] & ((|w_cnorm[6:0]) | w_cnorm[8]);
    assign w_csum   = {1'b0, w_cnorm[31:8]} + {24'd0, w_cround};
    assign w_cexp   = 8'd127 + {3'd0, w_cpos} + {7'd0, w_csum[24]};
    assign w_cfrac  = w_csum[24] ? 23'd0 : w_csum[22:0];
    assign w_cvt    = (fpu_data_a == 32'd0) ? 32'd0 : {fpu_data_a[31], w_cexp, w_cfrac};

    // ---------------- result select and register ----------------
    logic [31:0] w_fpu_res;

    always_comb begin
        w_fpu_res = '0;
        if (w_op[5])      w_fpu_res = {1'b0, fpu_data_a[30:0]};
        else if (w_op[6]) w_fpu_res = {31'd0, w_cmp};
        else if (w_op[7]) w_fpu_res = w_round;
        else if (w_op[8]) w_fpu_res = w_cvt;
    end

    logic [31:0] r_fpu_out;
    logic        r_fpu_valid;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_fpu_out   <= '0;
            r_fpu_valid <= 1'b0;
        end else begin
            r_fpu_valid <= w_launch;
            if (w_launch) r_fpu_out <= w_fpu_res;
        end
    end

    assign fpu_out       = r_fpu_out;
    assign fpu_out_valid = r_fpu_valid;

    // ---------------- FPR write arbitration ----------------
    logic        w_wr_en;
    logic [31:0] w_wr_data;

    always_comb begin
        w_wr_en   = 1'b1;
        w_wr_data = r_fpu_out;
        if (r_fpu_valid)                   w_wr_data = r_fpu_out;
        else if (load_finish && fl_valid)  w_wr_data = rdata;
        else if (wfpr_valid2)              w_wr_data = gpr_out;
        else                               w_wr_en   = 1'b0;
    end

    logic [31:0] r_fpr [32];
    logic        r_wfpr_finish;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < 32; i++) r_fpr[i] <= '0;
            r_wfpr_finish <= 1'b0;
        end else begin
            r_wfpr_finish <= w_wr_en;
            if (w_wr_en) r_fpr[regaddr] <= w_wr_data;
        end
    end

    assign wfpr_finish = r_wfpr_finish;

    for (genvar gi = 0; gi < 32; gi++) begin : g_fpr_flat
        assign fpr[32*gi +: 32] = r_fpr[gi];
    end

    logic w_unused;
    assign w_unused = &{1'b0, alu_data_c, w_rv[30:0], w_rshr[7:5], w_rshl[7:3], w_csum[23]};

endmodule
`default_nettype wire

// File: tb/tb_exec_datapath.sv
`default_nettype none
// ============================================================================
// Module  : tb_exec_datapath
// Purpose : directed self-checking bench for exec_datapath.
// Revision: 1.0
// ============================================================================
module tb_exec_datapath;

    logic          clk;
    logic          rstn;
    logic [31:0]   alu_data_a, alu_data_b;
    logic [4:0]    alu_data_c;
    logic [3:0]    alu_pattern;
    logic [31:0]   alu_out;
    logic [31:0]   fpu_data_a, fpu_data_b;
    logic [5:0]    fpu_data_c;
    logic [9:0]    fpu_in_valid;
    logic [31:0]   fpu_out;
    logic          fpu_out_valid;
    logic          load_finish, fl_valid;
    logic [31:0]   rdata;
    logic [4:0]    regaddr;
    logic          wfpr_valid2;
    logic [31:0]   gpr_out;
    logic [1023:0] fpr;
    logic          wfpr_finish;

    int n_pass  = 0;
    int n_total = 0;

    localparam logic [9:0] OP_ABS = 10'h041;
    localparam logic [9:0] OP_CMP = 10'h081;
    localparam logic [9:0] OP_RND = 10'h101;
    localparam logic [9:0] OP_CVT = 10'h201;

    localparam logic [3:0]  ALU_P [9] = '{4'd1, 4'd6, 4'd8, 4'd5, 4'd7, 4'd4, 4'd9, 4'd2, 4'd0};
    localparam logic [31:0] ALU_A [9] = '{32'd5, 32'd5, 32'd5, 32'd3, 32'd3, 32'd3, 32'd0,
                                          32'h0000_F0F0, 32'hCAFE_0001};
    localparam logic [31:0] ALU_B [9] = '{32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'hFFFF_FFFD,
                                          32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'd0,
                                          32'h0000_FF00, 32'h1234_5678};
    localparam logic [31:0] ALU_E [9] = '{32'd2, 32'd8, 32'd0, 32'h1000_0000, 32'hF000_0000,
                                          32'd0, 32'hFFFF_FFFF, 32'h0000_F000, 32'hCAFE_0001};

    localparam logic [9:0]  CV_OP [5] = '{OP_RND, OP_RND, OP_RND, OP_CVT, OP_CVT};
    localparam logic [31:0] CV_A  [5] = '{32'h4020_0000, 32'hBFC0_0000, 32'h4F32_D05E,
                                          32'd16777217, 32'hFFFF_FFFF};
    localparam logic [31:0] CV_E  [5] = '{32'd3, 32'hFFFF_FFFE, 32'h7FFF_FFFF,
                                          32'h4B80_0000, 32'hBF80_0000};

    exec_datapath dut (
        .clk          (clk),
        .rstn         (rstn),
        .alu_data_a   (alu_data_a),
        .alu_data_b   (alu_data_b),
        .alu_data_c   (alu_data_c),
        .alu_pattern  (alu_pattern),
        .alu_out      (alu_out),
        .fpu_data_a   (fpu_data_a),
        .fpu_data_b   (fpu_data_b),
        .fpu_data_c   (fpu_data_c),
        .fpu_in_valid (fpu_in_valid),
        .fpu_out      (fpu_out),
        .fpu_out_valid(fpu_out_valid),
        .load_finish  (load_finish),
        .fl_valid     (fl_valid),
        .rdata        (rdata),
        .regaddr      (regaddr),
        .wfpr_valid2  (wfpr_valid2),
        .gpr_out      (gpr_out),
        .fpr          (fpr),
        .wfpr_finish  (wfpr_finish)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one FPU request for exactly one sampling edge, return #1 after it.
    task automatic launch(input logic [9:0] v, input logic [31:0] a, input logic [31:0] b,
                          input logic [5:0] c, input logic [4:0] addr);
        fpu_in_valid = v;
        fpu_data_a   = a;
        fpu_data_b   = b;
        fpu_data_c   = c;
        regaddr      = addr;
        @(posedge clk); #1;
        fpu_in_valid = '0;
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        #1;
        n_total++;
        if (fpr !== '0) $display("FAIL reset_fpr: got nonzero fpr, want 0");
        else n_pass++;
        n_total++;
        if (fpu_out_valid !== 1'b0 || fpu_out !== 32'd0)
            $display("FAIL reset_fpu: valid=%b out=%h, want 0/0", fpu_out_valid, fpu_out);
        else n_pass++;
        n_total++;
        if (wfpr_finish !== 1'b0) $display("FAIL reset_finish: got %b want 0", wfpr_finish);
        else n_pass++;
        rstn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_alu;
        for (int i = 0; i < 9; i++) begin
            alu_pattern = ALU_P[i];
            alu_data_a  = ALU_A[i];
            alu_data_b  = ALU_B[i];
            alu_data_c  = 5'h1F;
            #1;
            n_total++;
            if (alu_out !== ALU_E[i])
                $display("FAIL alu_%0d (pattern %0d): got %h want %h", i, ALU_P[i], alu_out, ALU_E[i]);
            else n_pass++;
        end
    endtask

    task automatic test_compare;
        launch(OP_CMP, 32'h3F80_0000, 32'h4000_0000, 6'b001100, 5'd31);
        n_total++;
        if (fpu_out_valid !== 1'b1 || fpu_out !== 32'd1)
            $display("FAIL cmp_lt_out: valid=%b out=%h want 1/1", fpu_out_valid, fpu_out);
        else n_pass++;
        @(posedge clk); #1;
        n_total++;
        if (fpr[31*32 +: 32] !== 32'd1 || wfpr_finish !== 1'b1)
            $display("FAIL cmp_lt_fpr31: fpr31=%h finish=%b want 1/1", fpr[31*32 +: 32], wfpr_finish);
        else n_pass++;

        launch(OP_CMP, 32'h3F80_0000, 32'h4000_0000, 6'b100100, 5'd31);
        @(posedge clk); #1;
        n_total++;
        if (fpr[31*32 +: 32] !== 32'd0) $display("FAIL cmp_gt_fpr31: got %h want 0", fpr[31*32 +: 32]);
        else n_pass++;

        launch(OP_CMP, 32'h0000_0000, 32'h8000_0000, 6'b010100, 5'd31);
        @(posedge clk); #1;
        n_total++;
        if (fpr[31*32 +: 32] !== 32'd1) $display("FAIL cmp_eq_zero: got %h want 1", fpr[31*32 +: 32]);
        else n_pass++;
    endtask

    task automatic test_conversions;
        for (int i = 0; i < 5; i++) begin
            launch(CV_OP[i], CV_A[i], 32'd0, 6'd0, 5'd1);
            n_total++;
            if (fpu_out_valid !== 1'b1 || fpu_out !== CV_E[i])
                $display("FAIL conv_%0d: valid=%b out=%h want 1/%h", i, fpu_out_valid, fpu_out, CV_E[i]);
            else n_pass++;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_abs_reserved;
        launch(OP_ABS, 32'hC049_0FDB, 32'd0, 6'd0, 5'd2);
        n_total++;
        if (fpu_out_valid !== 1'b1 || fpu_out !== 32'h4049_0FDB)
            $display("FAIL abs: valid=%b out=%h want 1/40490fdb", fpu_out_valid, fpu_out);
        else n_pass++;

        launch(10'b00_0000_0011, 32'h4000_0000, 32'h4000_0000, 6'd0, 5'd3);
        n_total++;
        if (fpu_out_valid !== 1'b1 || fpu_out !== 32'd0)
            $display("FAIL reserved_op: valid=%b out=%h want 1/0", fpu_out_valid, fpu_out);
        else n_pass++;

        launch(10'b00_0000_0010, 32'h4000_0000, 32'd0, 6'd0, 5'd3);
        n_total++;
        if (fpu_out_valid !== 1'b0) $display("FAIL no_start: valid=%b want 0", fpu_out_valid);
        else n_pass++;

        launch(10'b00_0100_0011, 32'h4000_0000, 32'd0, 6'd0, 5'd3);
        n_total++;
        if (fpu_out_valid !== 1'b0) $display("FAIL multi_op: valid=%b want 0", fpu_out_valid);
        else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_arbitration;
        launch(OP_ABS, 32'hBF80_0000, 32'd0, 6'd0, 5'd4);
        load_finish = 1'b1;
        fl_valid    = 1'b1;
        rdata       = 32'h1234_5678;
        wfpr_valid2 = 1'b1;
        gpr_out     = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        n_total++;
        if (fpr[4*32 +: 32] !== 32'h3F80_0000 || wfpr_finish !== 1'b1)
            $display("FAIL arb_fpu_wins: fpr4=%h finish=%b want 3f800000/1", fpr[4*32 +: 32], wfpr_finish);
        else n_pass++;
        wfpr_valid2 = 1'b0;
        @(posedge clk); #1;
        n_total++;
        if (fpr[4*32 +: 32] !== 32'h1234_5678 || wfpr_finish !== 1'b1)
            $display("FAIL arb_load: fpr4=%h finish=%b want 12345678/1", fpr[4*32 +: 32], wfpr_finish);
        else n_pass++;
        load_finish = 1'b0;
        fl_valid    = 1'b0;
        @(posedge clk); #1;
        n_total++;
        if (wfpr_finish !== 1'b0 || fpr[4*32 +: 32] !== 32'h1234_5678)
            $display("FAIL arb_idle: fpr4=%h finish=%b want 12345678/0", fpr[4*32 +: 32], wfpr_finish);
        else n_pass++;
        wfpr_valid2 = 1'b1;
        regaddr     = 5'd0;
        @(posedge clk); #1;
        wfpr_valid2 = 1'b0;
        n_total++;
        if (fpr[31:0] !== 32'hDEAD_BEEF || wfpr_finish !== 1'b1)
            $display("FAIL arb_move_fpr0: fpr0=%h finish=%b want deadbeef/1", fpr[31:0], wfpr_finish);
        else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midop;
        launch(OP_CVT, 32'd7, 32'd0, 6'd0, 5'd2);
        rstn = 1'b0;
        #1;
        n_total++;
        if (fpu_out_valid !== 1'b0 || wfpr_finish !== 1'b0)
            $display("FAIL midrst_valid: valid=%b finish=%b want 0/0", fpu_out_valid, wfpr_finish);
        else n_pass++;
        n_total++;
        if (fpr !== '0) $display("FAIL midrst_fpr: got nonzero fpr, want 0");
        else n_pass++;
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;
        n_total++;
        if (fpu_out_valid !== 1'b0 || wfpr_finish !== 1'b0 || fpr !== '0)
            $display("FAIL midrst_release: valid=%b finish=%b want 0/0 with fpr 0", fpu_out_valid, wfpr_finish);
        else n_pass++;
    endtask

    initial begin
        rstn         = 1'b0;
        alu_data_a   = '0;
        alu_data_b   = '0;
        alu_data_c   = '0;
        alu_pattern  = '0;
        fpu_data_a   = '0;
        fpu_data_b   = '0;
        fpu_data_c   = '0;
        fpu_in_valid = '0;
        load_finish  = 1'b0;
        fl_valid     = 1'b0;
        rdata        = '0;
        regaddr      = '0;
        wfpr_valid2  = 1'b0;
        gpr_out      = '0;

        test_reset;
        test_alu;
        test_compare;
        test_conversions;
        test_abs_reserved;
        test_arbitration;
        test_reset_midop;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/exec_datapath.md
# exec_datapath

Execution datapath of the first multi-cycle core. It combines three pieces:
- a combinational integer ALU;
- a single-cycle floating-point unit covering abs, compare and int/float conversion;
- the 32×32 floating-point register file (FPR) with its write arbitration.

The decoder drives operands and one-hot strobes. Results go back to the GPR write path and to the FPR.

## Interface
- No parameters.
- `clk` — in, 1 — sole clock, rising edge.
- `rstn` — in, 1 — asynchronous, active-low reset.
- `alu_data_a` — in, 32 — ALU operand A. For shifts, A[4:0] is the shift amount.
- `alu_data_b` — in, 32 — ALU operand B.
- `alu_data_c` — in, 5 — reserved; ignored.
- `alu_pattern` — in, 4 — ALU operation select.
- `alu_out` — out, 32 — ALU result (combinational).
- `fpu_data_a` — in, 32 — FPU operand A (single float, or int32 for cvt).
- `fpu_data_b` — in, 32 — FPU operand B.
- `fpu_data_c` — in, 6 — compare condition code.
- `fpu_in_valid` — in, 10 — bit0 = start; bits 1..9 = one-hot operation.
- `fpu_out` — out, 32 — FPU result (registered).
- `fpu_out_valid` — out, 1 — one-cycle pulse with the result. Also acts as the FPR write request.
- `load_finish` — in, 1 — memory load data valid on `rdata`.
- `fl_valid` — in, 1 — the pending load targets the FPR.
- `rdata` — in, 32 — load data.
- `regaddr` — in, 5 — FPR destination index.
- `wfpr_valid2` — in, 1 — move-to-FPR request.
- `gpr_out` — in, 32 — move data.
- `fpr` — out, 32×32 packed — register file contents; `fpr[i]` = bits [32i+31:32i].
- `wfpr_finish` — out, 1 — write-done pulse.

## Operation
**ALU** (`alu_pattern`):
- 0: A
- 1: A+B
- 2: A&B
- 3: A|B
- 4: B << A[4:0]
- 5: B >> A[4:0] (logical)
- 6: A−B
- 7: B >>> A[4:0] (arithmetic)
- 8: signed A<B ? 1 : 0
- 9: ~(A|B)
- 10–15: 0
- Add and subtract wrap modulo 2^32 with no overflow flag.

**FPU op bits** (a launch occurs when bit0 = 1 and exactly one of bits 1..9 is set):
- 1–5 (add, sub, mul, div, sqrt): not implemented in this block. They still produce `fpu_out_valid` with `fpu_out` = 0, so the pipeline never stalls.
- 6 (abs): result = {1'b0, A[30:0]}.
- 7 (compare A vs B, selected by `fpu_data_c`):
  - 001100 → LT
  - 010100 → EQ
  - 011100 → LE
  - 100100 → GT
  - 101100 → NE
  - 110100 → GE
  - Result is 32'd1 if true, else 0. Any other code gives 0.
  - Ordering is IEEE sign-magnitude; +0 == −0. Denormal inputs are treated as zero. NaN is unsupported and compared as an ordinary bit pattern.
- 8 (round.w): float A → int32, round to nearest with ties away from zero. Saturates to 0x7FFFFFFF / 0x80000000 when out of range. Denormals give 0.
- 9 (cvt.s.w): int32 A → float, round to nearest even. An input of 0 gives +0.
- bit0 = 1 with zero or multiple op bits set: no pulse.
- bit0 = 0: nothing is launched, regardless of the other bits.

**FPR write** (one write per clock edge, in this priority order):
1. `fpu_out_valid` → `fpr[regaddr]` ← `fpu_out`
2. else `load_finish` && `fl_valid` → `fpr[regaddr]` ← `rdata`
3. else `wfpr_valid2` → `fpr[regaddr]` ← `gpr_out`

Additional rules:
- Lower-priority requests that lose the cycle are dropped, not queued.
- All 32 entries are writable, including `fpr[0]`. `fpr[31]` serves as the compare flag.

## Timing
- Reset (async, `rstn` = 0): all `fpr` entries = 0, `fpu_out` = 0, `fpu_out_valid` = 0, `wfpr_finish` = 0. Release is synchronous to `clk`.
- Reset asserted mid-operation: any in-flight FPU result is discarded; no pulse appears after release.
- ALU: purely combinational, zero latency.
- FPU latency: 1 cycle.
  - `fpu_in_valid` is sampled at edge N.
  - `fpu_out` and `fpu_out_valid` are valid between edges N and N+1.
  - The pulse lasts exactly 1 cycle unless a new launch is sampled at N+1.
  - If `fpu_in_valid` is held for K cycles, K back-to-back results are produced.
- FPR write:
  - The data is visible on `fpr` in the cycle after the edge that writes it.
  - `wfpr_finish` is a registered pulse in that same following cycle.
  - Back-to-back writes give consecutive `wfpr_finish` pulses.
- FPU-to-FPR chain: launch at edge N → `fpu_out_valid` during N..N+1 → written at edge N+1 → `wfpr_finish` during N+1..N+2.
- `regaddr` must be stable from launch until the edge that writes the FPR.

## Test plan
- **ALU sweep:**
  - A=5, B=0xFFFFFFFD: pattern 1 → 2, pattern 6 → 8, pattern 8 → 0.
  - A=3, B=0x80000000: pattern 5 → 0x10000000, pattern 7 → 0xF0000000, pattern 4 → 0.
  - Pattern 9 with A=B=0 → 0xFFFFFFFF.
- **Compare into fpr[31]:**
  - A=1.0 (0x3F800000), B=2.0 (0x40000000), c=001100, regaddr=31 → `fpr[31]`=1 two cycles after launch.
  - Same with c=100100 → 0.
  - +0 vs −0 with EQ → 1.
- **Conversions:**
  - round.w on 2.5 (0x40200000) → 3; on −1.5 → −2 (0xFFFFFFFE); on 3e9 → 0x7FFFFFFF.
  - cvt.s.w on 16777217 → 0x4B800000; on −1 → 0xBF800000.
- **Abs and reserved ops:**
  - abs on 0xC0490FDB → 0x40490FDB.
  - `fpu_in_valid` = 0b0000000011 → `fpu_out_valid` pulses with `fpu_out` = 0.
  - `fpu_in_valid` = 0b0000000010 (bit0 clear) → no pulse.
- **Write arbitration:** in one cycle assert `fpu_out_valid` (abs result 0x3F800000), `load_finish` + `fl_valid` (`rdata` = 0x12345678) and `wfpr_valid2`, with regaddr=4 → `fpr[4]` = 0x3F800000 and exactly one `wfpr_finish` pulse. Next cycle, a load alone writes 0x12345678.
- **Reset mid-operation:** launch cvt, then pull `rstn` low before the next edge → `fpu_out_valid` stays 0, all `fpr` = 0, `wfpr_finish` = 0.
